// File: rtl/msi_line_ctrl.sv
// rtl/msi_line_ctrl.sv - CPU request lookup and bus sequencing stage in front of the MSI next-state FSM
module msi_line_ctrl #(
   parameter int INDEX_W = 2,
   parameter int TAG_W   = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cpu_req_valid,
   output logic                       cpu_req_ready,
   input  logic                       cpu_req_we,
   input  logic [TAG_W+INDEX_W-1:0]   cpu_req_addr,
   output logic [1:0]                 state_in,
   output logic                       cpu_write_hit,
   output logic                       cpu_read_hit,
   output logic                       cpu_write_miss,
   output logic                       cpu_read_miss,
   input  logic [1:0]                 state_next,
   output logic                       bus_req_valid,
   output logic [1:0]                 bus_req_cmd,
   output logic [TAG_W+INDEX_W-1:0]   bus_req_addr,
   input  logic                       bus_req_ack,
   output logic                       cpu_resp_valid,
   output logic                       cpu_resp_hit,
   output logic                       cpu_resp_err
);

   localparam int A      = TAG_W + INDEX_W;
   localparam int NLINES = 1 << INDEX_W;

   localparam logic [1:0] L_INV = 2'b00;
   localparam logic [1:0] L_MOD = 2'b01;
   localparam logic [1:0] L_SHR = 2'b10;

   localparam logic [1:0] CMD_INVAL = 2'b00;
   localparam logic [1:0] CMD_WMISS = 2'b01;
   localparam logic [1:0] CMD_RMISS = 2'b10;
   localparam logic [1:0] CMD_WBACK = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_WB,
      ST_BUS,
      ST_RESP
   } ctrl_state_t;

   ctrl_state_t        ctrl_q;

   // Line array
   logic [1:0]         line_state_q [NLINES];
   logic [TAG_W-1:0]   line_tag_q   [NLINES];

   // Captured request and lookup context
   logic               we_q;
   logic [A-1:0]       addr_q;
   logic               hit_q;
   logic [1:0]         victim_state_q;
   logic [TAG_W-1:0]   victim_tag_q;
   logic [1:0]         next_q;
   logic [1:0]         pend_cmd_q;

   // Registered outputs
   logic               ready_q;
   logic [1:0]         state_in_q;
   logic [3:0]         strobe_q;   // {write_hit, read_hit, write_miss, read_miss}
   logic               bus_valid_q;
   logic [1:0]         bus_cmd_q;
   logic [A-1:0]       bus_addr_q;
   logic               resp_valid_q;
   logic               resp_hit_q;
   logic               resp_err_q;

   // Lookup of the incoming request address and the LOOKUP exit decision
   logic [INDEX_W-1:0] in_idx_d;
   logic [TAG_W-1:0]   in_tag_d;
   logic               in_hit_d;
   logic [1:0]         in_line_state_d;
   logic               next_err_d;
   logic               need_wb_d;
   logic               need_bus_d;
   logic [1:0]         bus_cmd_d;

   // Classify the incoming request against the committed line and pick the LOOKUP exit path
   always_comb begin
      in_idx_d        = cpu_req_addr[INDEX_W-1:0];
      in_tag_d        = cpu_req_addr[A-1:INDEX_W];
      in_line_state_d = line_state_q[in_idx_d];
      in_hit_d        = (in_line_state_d != L_INV) && (line_tag_q[in_idx_d] == in_tag_d);

      next_err_d = !((state_next == L_MOD) || (state_next == L_SHR));
      need_wb_d  = !hit_q && (victim_state_q == L_MOD) &&
                   (victim_tag_q != addr_q[A-1:INDEX_W]);
      need_bus_d = !hit_q || (we_q && (victim_state_q == L_SHR));
      if (!hit_q) begin
         bus_cmd_d = we_q ? CMD_WMISS : CMD_RMISS;
      end else begin
         bus_cmd_d = CMD_INVAL;
      end
   end

   // Request sequencer: accept, look up, write back victim, issue bus command, respond and commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q         <= ST_IDLE;
         for (int i = 0; i < NLINES; i++) begin
            line_state_q[i] <= L_INV;
            line_tag_q[i]   <= '0;
         end
         we_q           <= 1'b0;
         addr_q         <= '0;
         hit_q          <= 1'b0;
         victim_state_q <= L_INV;
         victim_tag_q   <= '0;
         next_q         <= L_INV;
         pend_cmd_q     <= CMD_INVAL;
         ready_q        <= 1'b0;
         state_in_q     <= L_INV;
         strobe_q       <= '0;
         bus_valid_q    <= 1'b0;
         bus_cmd_q      <= CMD_INVAL;
         bus_addr_q     <= '0;
         resp_valid_q   <= 1'b0;
         resp_hit_q     <= 1'b0;
         resp_err_q     <= 1'b0;
      end else begin
         case (ctrl_q)
            ST_IDLE: begin
               if (!ready_q) begin
                  // First cycle out of reset: open the request port
                  ready_q <= 1'b1;
               end else if (cpu_req_valid) begin
                  ready_q        <= 1'b0;
                  we_q           <= cpu_req_we;
                  addr_q         <= cpu_req_addr;
                  hit_q          <= in_hit_d;
                  victim_state_q <= in_line_state_d;
                  victim_tag_q   <= line_tag_q[in_idx_d];
                  state_in_q     <= in_hit_d ? in_line_state_d : L_INV;
                  strobe_q       <= { cpu_req_we &  in_hit_d,
                                     ~cpu_req_we &  in_hit_d,
                                      cpu_req_we & ~in_hit_d,
                                     ~cpu_req_we & ~in_hit_d };
                  ctrl_q         <= ST_LOOKUP;
               end
            end

            ST_LOOKUP: begin
               strobe_q   <= '0;
               state_in_q <= L_INV;
               next_q     <= state_next;
               pend_cmd_q <= bus_cmd_d;
               if (next_err_d) begin
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= hit_q;
                  resp_err_q   <= 1'b1;
                  ctrl_q       <= ST_RESP;
               end else if (need_wb_d) begin
                  bus_valid_q <= 1'b1;
                  bus_cmd_q   <= CMD_WBACK;
                  bus_addr_q  <= {victim_tag_q, addr_q[INDEX_W-1:0]};
                  ctrl_q      <= ST_WB;
               end else if (need_bus_d) begin
                  bus_valid_q <= 1'b1;
                  bus_cmd_q   <= bus_cmd_d;
                  bus_addr_q  <= addr_q;
                  ctrl_q      <= ST_BUS;
               end else begin
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= hit_q;
                  resp_err_q   <= 1'b0;
                  ctrl_q       <= ST_RESP;
               end
            end

            ST_WB: begin
               // Valid stays high: the request's own command follows the writeback directly
               if (bus_req_ack) begin
                  bus_cmd_q  <= pend_cmd_q;
                  bus_addr_q <= addr_q;
                  ctrl_q     <= ST_BUS;
               end
            end

            ST_BUS: begin
               if (bus_req_ack) begin
                  bus_valid_q  <= 1'b0;
                  bus_cmd_q    <= CMD_INVAL;
                  bus_addr_q   <= '0;
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= hit_q;
                  resp_err_q   <= 1'b0;
                  ctrl_q       <= ST_RESP;
               end
            end

            ST_RESP: begin
               resp_valid_q <= 1'b0;
               resp_hit_q   <= 1'b0;
               resp_err_q   <= 1'b0;
               if (!resp_err_q) begin
                  line_state_q[addr_q[INDEX_W-1:0]] <= next_q;
                  line_tag_q[addr_q[INDEX_W-1:0]]   <= addr_q[A-1:INDEX_W];
               end
               ready_q <= 1'b1;
               ctrl_q  <= ST_IDLE;
            end

            default: begin
               ctrl_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_req_ready  = ready_q;
   assign state_in       = state_in_q;
   assign cpu_write_hit  = strobe_q[3];
   assign cpu_read_hit   = strobe_q[2];
   assign cpu_write_miss = strobe_q[1];
   assign cpu_read_miss  = strobe_q[0];
   assign bus_req_valid  = bus_valid_q;
   assign bus_req_cmd    = bus_cmd_q;
   assign bus_req_addr   = bus_addr_q;
   assign cpu_resp_valid = resp_valid_q;
   assign cpu_resp_hit   = resp_hit_q;
   assign cpu_resp_err   = resp_err_q;

endmodule

// File: tb/tb_msi_line_ctrl.sv
// tb/tb_msi_line_ctrl.sv - scoreboard bench for msi_line_ctrl with an MSI FSM responder and bus acker
module tb_msi_line_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_req_valid;
   logic       cpu_req_ready;
   logic       cpu_req_we;
   logic [7:0] cpu_req_addr;
   logic [1:0] state_in;
   logic       cpu_write_hit;
   logic       cpu_read_hit;
   logic       cpu_write_miss;
   logic       cpu_read_miss;
   logic [1:0] state_next;
   logic       bus_req_valid;
   logic [1:0] bus_req_cmd;
   logic [7:0] bus_req_addr;
   logic       bus_req_ack;
   logic       cpu_resp_valid;
   logic       cpu_resp_hit;
   logic       cpu_resp_err;

   always #5 clk = ~clk;

   msi_line_ctrl #(.INDEX_W(2), .TAG_W(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .cpu_req_valid  (cpu_req_valid),
      .cpu_req_ready  (cpu_req_ready),
      .cpu_req_we     (cpu_req_we),
      .cpu_req_addr   (cpu_req_addr),
      .state_in       (state_in),
      .cpu_write_hit  (cpu_write_hit),
      .cpu_read_hit   (cpu_read_hit),
      .cpu_write_miss (cpu_write_miss),
      .cpu_read_miss  (cpu_read_miss),
      .state_next     (state_next),
      .bus_req_valid  (bus_req_valid),
      .bus_req_cmd    (bus_req_cmd),
      .bus_req_addr   (bus_req_addr),
      .bus_req_ack    (bus_req_ack),
      .cpu_resp_valid (cpu_resp_valid),
      .cpu_resp_hit   (cpu_resp_hit),
      .cpu_resp_err   (cpu_resp_err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [1:0] cmd;
      logic [7:0] addr;
   } bus_t;

   bus_t       bus_exp  [$];
   logic [5:0] look_exp [$];   // {state_in, write_hit, read_hit, write_miss, read_miss}
   logic [1:0] resp_exp [$];   // {hit, err}

   logic [1:0] m_state [4];
   logic [5:0] m_tag   [4];

   logic force_bad;
   int   ack_delay;

   // MSI next-state FSM stand-in
   always_comb begin
      state_next = 2'b00;
      if (!force_bad) begin
         if (cpu_read_miss)  state_next = 2'b10;
         if (cpu_write_miss) state_next = 2'b01;
         if (cpu_read_hit)   state_next = state_in;
         if (cpu_write_hit)  state_next = 2'b01;
      end
   end

   // Bus responder: acks each command after ack_delay cycles, checks it against the scoreboard
   int         phase_cnt;
   logic [1:0] held_cmd;
   logic [7:0] held_addr;
   always @(negedge clk) begin
      logic was_ack;
      if (rst) begin
         bus_req_ack = 1'b0;
         phase_cnt   = 0;
      end else begin
         was_ack     = bus_req_ack;
         bus_req_ack = 1'b0;
         if (was_ack) phase_cnt = 0;
         if (bus_req_valid) begin
            if (phase_cnt == 0) begin
               held_cmd  = bus_req_cmd;
               held_addr = bus_req_addr;
            end else begin
               check("bus_cmd_stable", 32'(bus_req_cmd), 32'(held_cmd));
               check("bus_addr_stable", 32'(bus_req_addr), 32'(held_addr));
            end
            if (phase_cnt >= ack_delay) begin
               bus_req_ack = 1'b1;
               if (bus_exp.size() == 0) begin
                  check("bus_unexpected", {22'd0, bus_req_cmd, bus_req_addr}, 32'hFFFF_FFFF);
               end else begin
                  bus_t e;
                  e = bus_exp.pop_front();
                  check("bus_cmd", 32'(bus_req_cmd), 32'(e.cmd));
                  check("bus_addr", 32'(bus_req_addr), 32'(e.addr));
               end
            end
            phase_cnt++;
         end
      end
   end

   // Lookup strobe monitor
   always @(negedge clk) begin
      if (!rst && (cpu_write_hit | cpu_read_hit | cpu_write_miss | cpu_read_miss)) begin
         if (look_exp.size() == 0) begin
            check("lookup_unexpected", 32'd1, 32'd0);
         end else begin
            logic [5:0] e;
            e = look_exp.pop_front();
            check("lookup_strobes",
                  32'({state_in, cpu_write_hit, cpu_read_hit, cpu_write_miss, cpu_read_miss}),
                  32'(e));
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_state[i] = 2'b00;
         m_tag[i]   = 6'd0;
      end
      bus_exp.delete();
      look_exp.delete();
      resp_exp.delete();
   endtask

   // Predict the transaction, then present it to the DUT
   task automatic issue(input logic we, input logic [7:0] addr, input logic bad, input int delay);
      logic [1:0] idx;
      logic [5:0] tag;
      logic       hit;
      logic [1:0] st_in;
      logic [1:0] nxt;
      bus_t       b;
      int         waited;
      idx   = addr[1:0];
      tag   = addr[7:2];
      hit   = (m_state[idx] != 2'b00) && (m_tag[idx] == tag);
      st_in = hit ? m_state[idx] : 2'b00;
      look_exp.push_back({st_in, we & hit, ~we & hit, we & ~hit, ~we & ~hit});
      if (!hit)    nxt = we ? 2'b01 : 2'b10;
      else if (we) nxt = 2'b01;
      else         nxt = st_in;
      if (bad) begin
         resp_exp.push_back({hit, 1'b1});
      end else begin
         if (!hit && m_state[idx] == 2'b01 && m_tag[idx] != tag) begin
            b.cmd = 2'b11; b.addr = {m_tag[idx], idx};
            bus_exp.push_back(b);
         end
         if (!hit) begin
            b.cmd = we ? 2'b01 : 2'b10; b.addr = addr;
            bus_exp.push_back(b);
         end else if (we && st_in == 2'b10) begin
            b.cmd = 2'b00; b.addr = addr;
            bus_exp.push_back(b);
         end
         resp_exp.push_back({hit, 1'b0});
         m_state[idx] = nxt;
         m_tag[idx]   = tag;
      end
      force_bad = bad;
      ack_delay = delay;
      waited = 0;
      @(negedge clk);
      while (!cpu_req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!cpu_req_ready) check("ready_timeout", 32'd0, 32'd1);
      cpu_req_valid = 1'b1;
      cpu_req_we    = we;
      cpu_req_addr  = addr;
      @(posedge clk);
      #1;
      cpu_req_valid = 1'b0;
   endtask

   // Wait for the completion pulse; exp_lat < 0 skips the latency check
   task automatic wait_resp(input int exp_lat);
      int   lat;
      logic got;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 200) begin
         @(negedge clk);
         lat++;
         if (cpu_resp_valid) got = 1'b1;
      end
      if (!got) begin
         check("resp_timeout", 32'd0, 32'd1);
      end else begin
         if (resp_exp.size() == 0) begin
            check("resp_unexpected", 32'd1, 32'd0);
         end else begin
            logic [1:0] e;
            e = resp_exp.pop_front();
            check("resp_hit_err", 32'({cpu_resp_hit, cpu_resp_err}), 32'(e));
         end
         if (exp_lat >= 0) check("resp_latency", 32'(lat), 32'(exp_lat));
         check("strobes_idle_in_resp",
               32'({state_in, cpu_write_hit, cpu_read_hit, cpu_write_miss, cpu_read_miss}), 32'd0);
      end
      force_bad = 1'b0;
   endtask

   initial begin
      int waited;
      rst           = 1'b1;
      cpu_req_valid = 1'b0;
      cpu_req_we    = 1'b0;
      cpu_req_addr  = 8'h00;
      force_bad     = 1'b0;
      ack_delay     = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", 32'(cpu_req_ready), 32'd0);
      check("reset_bus_valid", 32'(bus_req_valid), 32'd0);
      check("reset_resp_valid", 32'(cpu_resp_valid), 32'd0);
      check("reset_state_in", 32'(state_in), 32'd0);
      rst = 1'b0;

      // 1: cold read miss
      issue(1'b0, 8'h05, 1'b0, 0);
      wait_resp(3);
      // 2: read hit on SHARED, no bus
      issue(1'b0, 8'h05, 1'b0, 0);
      wait_resp(2);
      // 3: write hit on SHARED -> invalidate
      issue(1'b1, 8'h05, 1'b0, 0);
      wait_resp(3);
      // 4: same-index read over MODIFIED victim, acks held off
      issue(1'b0, 8'h45, 1'b0, 3);
      wait_resp(10);
      // write miss on another index, then hits on MODIFIED
      issue(1'b1, 8'h0A, 1'b0, 1);
      wait_resp(4);
      issue(1'b0, 8'h0A, 1'b0, 0);
      wait_resp(2);
      issue(1'b1, 8'h0A, 1'b0, 0);
      wait_resp(2);
      // 5: illegal next state leaves line untouched
      issue(1'b1, 8'h45, 1'b1, 0);
      wait_resp(2);
      issue(1'b0, 8'h45, 1'b0, 0);
      wait_resp(2);

      // 6: reset while a bus command is outstanding
      issue(1'b0, 8'h0F, 1'b0, 1000);
      waited = 0;
      while (!bus_req_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("bus_pending_before_reset", 32'(bus_req_valid), 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_drop_bus_valid", 32'(bus_req_valid), 32'd0);
      check("async_drop_ready", 32'(cpu_req_ready), 32'd0);
      model_reset();
      ack_delay = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      waited = 0;
      while (!cpu_req_ready && waited < 5) begin
         @(negedge clk);
         waited++;
      end
      check("ready_after_reset", 32'(cpu_req_ready), 32'd1);
      issue(1'b0, 8'h45, 1'b0, 0);
      wait_resp(3);
      issue(1'b1, 8'h0A, 1'b0, 0);
      wait_resp(3);

      repeat (3) @(negedge clk);
      check("bus_queue_drained", 32'(bus_exp.size()), 32'd0);
      check("lookup_queue_drained", 32'(look_exp.size()), 32'd0);
      check("resp_queue_drained", 32'(resp_exp.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
